// File: rtl/packet_assembler.sv
// HDMI data-island packet assembler: serialises header + 4 subpackets with BCH ECC.
// Optional build macro PACKET_ASSEMBLER_INPUT_LATCH_EN captures inputs at counter 0.

module packet_assembler_lane #(
  parameter logic [7:0] ECC_POLY = 8'h83
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        data_island_period,
  input  logic [4:0]  counter,
  input  logic [55:0] sub_bits,
  output logic        even_bit,
  output logic        odd_bit
);
  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    ecc_step = (e >> 1) ^ ((e[0] ^ b) ? ECC_POLY : 8'h00);
  endfunction

  logic [7:0]  ecc;
  logic [55:0] sub_use;
  logic [63:0] stream;
  logic [5:0]  even_idx, odd_idx;

`ifdef PACKET_ASSEMBLER_INPUT_LATCH_EN
  logic [55:0] sub_q;
  always_ff @(posedge clk_pixel)
    if (!reset) sub_q <= '0;
    else if (data_island_period && counter == 5'd0) sub_q <= sub_bits;
  assign sub_use = (counter == 5'd0) ? sub_bits : sub_q;
`else
  assign sub_use = sub_bits;
`endif

  // Data bits occupy pixels 0..27, the ECC byte pixels 28..31, two bits per pixel.
  assign stream   = {ecc, sub_use};
  assign even_idx = {counter, 1'b0};
  assign odd_idx  = {counter, 1'b1};
  assign even_bit = stream[even_idx];
  assign odd_bit  = stream[odd_idx];

  always_ff @(posedge clk_pixel)
    if (!reset || !data_island_period || counter == 5'd31) ecc <= '0;
    else if (counter < 5'd28) ecc <= ecc_step(ecc_step(ecc, stream[even_idx]), stream[odd_idx]);
endmodule

module packet_assembler #(
  parameter logic [7:0] ECC_POLY = 8'h83
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             data_island_period,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  output logic [4:0]       counter,
  output logic             packet_enable,
  output logic [8:0]       packet_data
);
  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    ecc_step = (e >> 1) ^ ((e[0] ^ b) ? ECC_POLY : 8'h00);
  endfunction

  logic [7:0]  header_ecc;
  logic [23:0] header_use;
  logic [31:0] header_stream;
  logic [3:0]  even, odd;

`ifdef PACKET_ASSEMBLER_INPUT_LATCH_EN
  logic [23:0] header_q;
  always_ff @(posedge clk_pixel)
    if (!reset) header_q <= '0;
    else if (data_island_period && counter == 5'd0) header_q <= header;
  assign header_use = (counter == 5'd0) ? header : header_q;
`else
  assign header_use = header;
`endif

  assign header_stream = {header_ecc, header_use};

  always_ff @(posedge clk_pixel)
    if (!reset || !data_island_period) begin
      counter    <= '0;
      header_ecc <= '0;
    end else begin
      counter <= counter + 5'd1;
      if (counter == 5'd31)     header_ecc <= '0;
      else if (counter < 5'd24) header_ecc <= ecc_step(header_ecc, header_stream[counter]);
    end

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_lane
      packet_assembler_lane #(.ECC_POLY(ECC_POLY)) u_lane (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .counter            (counter),
        .sub_bits           (sub[i]),
        .even_bit           (even[i]),
        .odd_bit            (odd[i])
      );
    end
  endgenerate

  assign packet_enable = data_island_period && (counter == 5'd31);
  assign packet_data   = data_island_period ? {odd, even, header_stream[counter]} : 9'h000;
endmodule

// File: tb/tb_packet_assembler.sv
// Randomised bench for packet_assembler against a packet-level reference model.
module tb_packet_assembler;
  logic             clk_pixel = 1'b0;
  logic             reset;
  logic             data_island_period;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [4:0]       counter;
  logic             packet_enable;
  logic [8:0]       packet_data;

`ifdef PACKET_ASSEMBLER_INPUT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  packet_assembler dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .counter            (counter),
    .packet_enable      (packet_enable),
    .packet_data        (packet_data)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_vec = 0, n_err = 0;
  int p = 0;
  logic [23:0]      hq, hbits;
  logic [3:0][55:0] sq, sbits;
  logic [8:0]       last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h (pixel %0d, t=%0t)", tag, obs, exp, p, $time);
    end
  endtask

  // Bit-serial BCH over the first n bits, LSB first, poly 0x83.
  function automatic logic [7:0] ecc_of(input logic [55:0] bits, input int n);
    logic [7:0] e = 8'h00;
    for (int k = 0; k < n; k++) e = (e >> 1) ^ ((e[0] ^ bits[k]) ? 8'h83 : 8'h00);
    return e;
  endfunction

  task automatic model_eval(output logic [8:0] d, output logic e, output logic [4:0] c);
    logic [23:0]      eh;
    logic [3:0][55:0] es;
    logic [7:0]       b;
    c = 5'(p);
    d = '0;
    e = 1'b0;
    if (!data_island_period) return;
    if (p == 0) begin hq = header; sq = sub; end
    eh = (LATCH && p != 0) ? hq : header;
    es = (LATCH && p != 0) ? sq : sub;
    e = (p == 31);
    if (p < 24) begin
      d[0] = eh[p];
      hbits[p] = eh[p];
    end else begin
      b = ecc_of({32'h0, hbits}, 24);
      d[0] = b[p-24];
    end
    for (int i = 0; i < 4; i++) begin
      if (p < 28) begin
        d[1+i] = es[i][2*p];
        d[5+i] = es[i][2*p+1];
        sbits[i][2*p]   = es[i][2*p];
        sbits[i][2*p+1] = es[i][2*p+1];
      end else begin
        b = ecc_of(sbits[i], 56);
        d[1+i] = b[2*(p-28)];
        d[5+i] = b[2*(p-28)+1];
      end
    end
  endtask

  task automatic step();
    logic [8:0] ed;
    logic       ee;
    logic [4:0] ec;
    model_eval(ed, ee, ec);
    @(negedge clk_pixel);
    chk("counter", 32'(counter), 32'(ec));
    chk("packet_enable", 32'(packet_enable), 32'(ee));
    chk("packet_data", 32'(packet_data), 32'(ed));
    last_data = packet_data;
    @(posedge clk_pixel);
    if (!reset || !data_island_period) p = 0;
    else p = (p + 1) % 32;
    #1;
  endtask

  task automatic rand_inputs();
    header = 24'($urandom);
    for (int i = 0; i < 4; i++) sub[i] = {24'($urandom), $urandom};
  endtask

  initial begin
    logic [7:0] obs_ecc;
    reset = 1'b0; data_island_period = 1'b1; header = '0; sub = '0;
    hq = '0; sq = '0; hbits = '0; sbits = '0;
    @(posedge clk_pixel); #1;

    // Reset held with the period asserted, then a null packet and wrap.
    repeat (3) step();
    reset = 1'b1;
    repeat (32) step();

    // Single header bit: header ECC must be 0x4A.
    header = 24'h000001;
    obs_ecc = '0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k >= 24) obs_ecc[k-24] = last_data[0];
    end
    chk("hdr_ecc_single_bit", 32'(obs_ecc), 32'h4A);

    // Back-to-back random packets.
    for (int n = 0; n < 100; n++) begin
      rand_inputs();
      repeat (32) step();
    end

    // Abort at counter 12, idle 4 cycles, fresh packet.
    rand_inputs();
    repeat (12) step();
    data_island_period = 1'b0;
    repeat (4) step();
    data_island_period = 1'b1;
    rand_inputs();
    repeat (32) step();

    // Header changed mid-packet at counter 5.
    rand_inputs();
    repeat (5) step();
    header = 24'($urandom);
    for (int i = 0; i < 4; i++) sub[i] = {24'($urandom), $urandom};
    repeat (27) step();

    // Reset mid-packet takes priority over the period.
    rand_inputs();
    repeat (10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    rand_inputs();
    repeat (32) step();

    // Idle after the period.
    data_island_period = 1'b0;
    rand_inputs();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
